// File: rtl/mult_div_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_pkg
//   Shared definitions for the multiply/divide unit:
//     - operation encoding (OP_MULTU / OP_MULT / OP_DIVU / OP_DIV)
//     - FSM state type (IDLE / RUN / FIN)
//     - small decode helpers for the op field
//   Used by mult_div_unit and the verification bench.
// ---------------------------------------------------------------------------
package mult_div_pkg;

  localparam logic [1:0] OP_MULTU = 2'd0;
  localparam logic [1:0] OP_MULT  = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;
  localparam logic [1:0] OP_DIV   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } mdu_state_e;

  // True for either divide flavour.
  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  // True for the two's-complement flavours (only honoured in signed builds).
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_negate.sv
// ---------------------------------------------------------------------------
// mdu_negate
//   Conditional two's complement: dout = neg ? -din : din.
//   Purely combinational; used to take operand magnitudes and to restore the
//   sign of products, quotients and remainders.
//
//   Parameters
//     DATA_W  operand width
//   Ports
//     din   [DATA_W-1:0]  input value
//     neg   1             negate when set
//     dout  [DATA_W-1:0]  result (the most negative value maps to itself)
// ---------------------------------------------------------------------------
module mdu_negate #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] din,
  input  logic              neg,
  output logic [DATA_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (neg) begin
      dout = (~din) + DATA_W'(1);
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative MIPS-style multiply/divide unit with architectural HI/LO.
//   One iteration per cycle: shift-add multiply or restoring divide, DATA_W
//   iterations, then a single FIN cycle carrying the done pulse.
//   Start-to-done latency is DATA_W+1 cycles.
//
//   Build option
//     MULT_DIV_SIGNED_EN  defined: MULT/DIV work on two's-complement operands.
//                         undefined: op[0] is ignored, everything unsigned and
//                         no magnitude / sign-fix hardware is built.
//
//   Parameters
//     DATA_W  operand / HI / LO width (even, >= 4)
//     CNT_W   iteration counter width
//   Ports
//     clk, rst            clock, asynchronous active-high reset
//     start, op, a, b     request (accepted only while busy=0)
//     hi_we, lo_we, wdata MTHI / MTLO writes (dropped while busy or on start)
//     busy, done          in progress / one-cycle completion pulse
//     div_zero            last completed divide had a zero divisor
//     hi, lo              architectural HI / LO
// ---------------------------------------------------------------------------
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  // Control / architectural state
  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              dz_q, dz_d;

  // Datapath working registers (no reset needed: only read while in RUN)
  logic              is_div_q, is_div_d;
  logic              bz_q, bz_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] upper_q, upper_d;
  logic [DATA_W-1:0] lower_q, lower_d;

  logic              accept;
  logic              last_iter;

  // Operand magnitudes and one-iteration results
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W-1:0]   div_diff;
  logic                div_fits;
  logic [DATA_W-1:0]   upper_n, lower_n;

  // Sign-corrected results of the final iteration
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quot_fix, rem_fix;
  logic [DATA_W-1:0]   res_hi, res_lo;

  // -------------------------------------------------------------------------
  // Accept / termination decode
  // -------------------------------------------------------------------------
  always_comb begin
    accept    = start && (state_q != ST_RUN);
    last_iter = (state_q == ST_RUN) && (cnt_q == CNT_W'(DATA_W - 1));
  end

  // -------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_iter) state_d = ST_FIN;
      ST_FIN:  state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_FIN);
  end

  // -------------------------------------------------------------------------
  // Operand magnitudes and result sign correction
  // -------------------------------------------------------------------------
`ifdef MULT_DIV_SIGNED_EN
  logic sa_q, sa_d;
  logic sb_q, sb_d;
  logic neg_a, neg_b;

  always_comb begin
    neg_a = op_is_signed(op) && a[DATA_W-1];
    neg_b = op_is_signed(op) && b[DATA_W-1];
    sa_d  = accept ? neg_a : sa_q;
    sb_d  = accept ? neg_b : sb_q;
  end

  always_ff @(posedge clk) begin
    sa_q <= sa_d;
    sb_q <= sb_d;
  end

  mdu_negate #(.DATA_W(DATA_W)) u_mag_a (.din(a), .neg(neg_a), .dout(a_mag));
  mdu_negate #(.DATA_W(DATA_W)) u_mag_b (.din(b), .neg(neg_b), .dout(b_mag));

  // Product and quotient take sign(a) ^ sign(b); the remainder follows the
  // dividend. MIN / -1 needs no special case: the magnitude quotient 2^(W-1)
  // negates back onto MIN and the remainder is zero.
  mdu_negate #(.DATA_W(2*DATA_W)) u_fix_prod (
    .din ({upper_n, lower_n}),
    .neg (sa_q ^ sb_q),
    .dout(prod_fix)
  );
  mdu_negate #(.DATA_W(DATA_W)) u_fix_quot (.din(lower_n), .neg(sa_q ^ sb_q), .dout(quot_fix));
  mdu_negate #(.DATA_W(DATA_W)) u_fix_rem  (.din(upper_n), .neg(sa_q),        .dout(rem_fix));
`else
  assign a_mag    = a;
  assign b_mag    = b;
  assign prod_fix = {upper_n, lower_n};
  assign quot_fix = lower_n;
  assign rem_fix  = upper_n;
`endif

  // -------------------------------------------------------------------------
  // One iteration. Multiply: {upper,lower} = {partial product, multiplier},
  // add-then-shift-right. Divide: {upper,lower} = {remainder, dividend/quot},
  // shift-left then trial subtract; the quotient bit enters lower[0].
  // -------------------------------------------------------------------------
  always_comb begin
    mul_sum   = {1'b0, upper_q} + (lower_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {upper_q, lower_q[DATA_W-1]};
    div_fits  = (div_shift >= {1'b0, mcand_q});
    // When the trial fits the true difference is below 2^DATA_W, so the
    // truncated subtraction is exact.
    div_diff  = div_shift[DATA_W-1:0] - mcand_q;
    if (is_div_q) begin
      upper_n = div_fits ? div_diff : div_shift[DATA_W-1:0];
      lower_n = {lower_q[DATA_W-2:0], div_fits};
    end else begin
      upper_n = mul_sum[DATA_W:1];
      lower_n = {mul_sum[0], lower_q[DATA_W-1:1]};
    end
  end

  always_comb begin
    is_div_d = is_div_q;
    bz_d     = bz_q;
    mcand_d  = mcand_q;
    upper_d  = upper_q;
    lower_d  = lower_q;
    if (accept) begin
      is_div_d = op_is_div(op);
      bz_d     = (b == '0);
      upper_d  = '0;
      if (op_is_div(op)) begin
        lower_d = a_mag;
        mcand_d = b_mag;
      end else begin
        lower_d = b_mag;
        mcand_d = a_mag;
      end
    end else if (state_q == ST_RUN) begin
      upper_d = upper_n;
      lower_d = lower_n;
    end
  end

  always_ff @(posedge clk) begin
    is_div_q <= is_div_d;
    bz_q     <= bz_d;
    mcand_q  <= mcand_d;
    upper_q  <= upper_d;
    lower_q  <= lower_d;
  end

  // -------------------------------------------------------------------------
  // Result selection. A zero divisor runs the full latency; the remainder
  // path already yields a (magnitude then dividend sign), only lo is forced.
  // -------------------------------------------------------------------------
  always_comb begin
    if (is_div_q) begin
      res_lo = bz_q ? '1 : quot_fix;
      res_hi = rem_fix;
    end else begin
      res_lo = prod_fix[DATA_W-1:0];
      res_hi = prod_fix[2*DATA_W-1:DATA_W];
    end
  end

  // -------------------------------------------------------------------------
  // Counter, HI/LO and div_zero. MTHI/MTLO only land when idle and no start
  // is being accepted in the same cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    dz_d  = dz_q;
    if (accept) begin
      cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (last_iter) begin
      hi_d = res_hi;
      lo_d = res_lo;
      dz_d = is_div_q && bz_q;
    end else if ((state_q != ST_RUN) && !start) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      dz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      dz_q  <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit (DATA_W = 32). A vector table is
//   run through the unit with expected results queued at issue time and
//   compared when done pulses; hand-written sequences cover busy-time
//   writes, ignored starts and reset abort. Honours MULT_DIV_SIGNED_EN.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;
  import mult_div_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  vec_t sb_q[$];
  vec_t tbl[12];
  vec_t exp_v;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.DATA_W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model built on 64-bit language arithmetic.
  function automatic vec_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    vec_t v;
    logic sgn;
    logic signed [63:0] sx, sy, p, q, r;
    v.op = o; v.a = x; v.b = y; v.dz = 1'b0;
`ifdef MULT_DIV_SIGNED_EN
    sgn = o[0];
`else
    sgn = 1'b0;
`endif
    sx = sgn ? {{32{x[31]}}, x} : {32'b0, x};
    sy = sgn ? {{32{y[31]}}, y} : {32'b0, y};
    if (!o[1]) begin
      p    = sx * sy;
      v.hi = p[63:32];
      v.lo = p[31:0];
    end else if (y == '0) begin
      v.hi = x;
      v.lo = '1;
      v.dz = 1'b1;
    end else begin
      q    = sx / sy;
      r    = sx % sy;
      v.hi = r[31:0];
      v.lo = q[31:0];
    end
    return v;
  endfunction

  // Drive a one-cycle start; returns #1 after the accepting edge (RUN cycle 1).
  task automatic issue(input vec_t v, input logic with_we, input logic push);
    @(posedge clk); #1;
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    hi_we = with_we; lo_we = with_we; wdata = 32'h11111111;
    if (push) sb_q.push_back(v);
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  task automatic wait_done(input int lat0, input string name);
    int lat;
    lat = lat0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) $display("FAIL %s_timeout: no done within %0d cycles", name, lat);
    chk({name, "_latency"}, 64'(lat), 64'(W + 1));
    chk({name, "_busy_in_fin"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk({name, "_done_single"}, 64'(done), 64'd0);
  endtask

  // Scoreboard: compare on every done pulse.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no completion");
      end else begin
        exp_v = sb_q.pop_front();
        chk("result_hi", 64'(hi), 64'(exp_v.hi));
        chk("result_lo", 64'(lo), 64'(exp_v.lo));
        chk("result_div_zero", 64'(div_zero), 64'(exp_v.dz));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    int seen;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

    tbl[0]  = '{op: OP_MULTU, a: 32'hFFFFFFFF, b: 32'd2, hi: 32'h00000001, lo: 32'hFFFFFFFE, dz: 1'b0};
    tbl[1]  = '{op: OP_DIVU,  a: 32'h00001234, b: 32'd0, hi: 32'h00001234, lo: 32'hFFFFFFFF, dz: 1'b1};
`ifdef MULT_DIV_SIGNED_EN
    tbl[2]  = '{op: OP_DIV, a: 32'hFFFFFFF9, b: 32'd2, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD, dz: 1'b0};
    tbl[7]  = '{op: OP_DIV, a: 32'h80000000, b: 32'hFFFFFFFF, hi: 32'h00000000, lo: 32'h80000000, dz: 1'b0};
`else
    tbl[2]  = model(OP_DIV, 32'hFFFFFFF9, 32'd2);
    tbl[7]  = model(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
`endif
    tbl[3]  = model(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tbl[4]  = model(OP_MULT,  32'hFFFFFFFD, 32'd5);
    tbl[5]  = model(OP_MULT,  32'h80000000, 32'h80000000);
    tbl[6]  = model(OP_DIVU,  32'd100,      32'd7);
    tbl[8]  = model(OP_DIV,   32'd7,        32'hFFFFFFFE);
    tbl[9]  = model(OP_DIVU,  32'd5,        32'd10);
    tbl[10] = model(OP_MULT,  32'h12345678, 32'd0);
    tbl[11] = model(OP_DIV,   32'hFFFFFFFB, 32'd0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_div_zero", 64'(div_zero), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i], 1'b0, 1'b1);
      wait_done(1, "vec");
    end

    // MTHI while busy is dropped; HI/LO hold during RUN (prev hi=FFFFFFFB)
    issue(model(OP_MULTU, 32'd3, 32'd4), 1'b0, 1'b1);
    hi_we = 1'b1; wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("busy_write_hi_dropped", 64'(hi), 64'hFFFFFFFB);
    chk("run_lo_hold", 64'(lo), 64'hFFFFFFFF);
    wait_done(2, "busy_write");

    // MTHI / MTLO while idle
    @(posedge clk); #1;
    hi_we = 1'b1; wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("idle_write_hi", 64'(hi), 64'hA5A5A5A5);
    chk("idle_write_lo_untouched", 64'(lo), 64'd12);
    lo_we = 1'b1; wdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    lo_we = 1'b0;
    chk("idle_write_lo", 64'(lo), 64'h5A5A5A5A);

    // start with writes in the same cycle: start wins, writes dropped
    issue(model(OP_MULTU, 32'd6, 32'd7), 1'b1, 1'b1);
    chk("start_we_busy", 64'(busy), 64'd1);
    chk("start_we_hi", 64'(hi), 64'hA5A5A5A5);
    chk("start_we_lo", 64'(lo), 64'h5A5A5A5A);
    wait_done(1, "start_we");

    // Second start at RUN cycle 5 is ignored
    issue(model(OP_MULT, 32'hFFFFFFFE, 32'd9), 1'b0, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; op = OP_MULT; a = 32'd100; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = n_done;
    wait_done(6, "ignored_start");
    repeat (W + 5) @(posedge clk);
    #1;
    chk("ignored_start_done_count", 64'(n_done), 64'(d0 + 1));

    // Reset during RUN cycle 10 aborts without done
    issue(model(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF), 1'b0, 1'b1);
    repeat (9) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_div_zero", 64'(div_zero), 64'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    d0 = n_done;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_done_count", 64'(n_done), 64'(d0));
    chk("abort_hi_after", 64'(hi), 64'd0);

    // Unit recovers after abort
    issue(model(OP_DIVU, 32'd100, 32'd7), 1'b0, 1'b1);
    wait_done(1, "recover");
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
